// File: rtl/seg_display_ctrl.sv
// Binary-to-BCD converting, multiplexed seven-segment display controller.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks zero digits above the most-significant nonzero digit.
module seg_display_ctrl #(
    parameter int DIGITS      = 4,
    parameter int IN_WIDTH    = 14,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] value,
    input  logic                load,
    output logic                busy,
    output logic                overflow,
    output logic [7:0]          cathode,
    output logic [DIGITS-1:0]   anode
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Enough BCD digits to hold 2^IN_WIDTH-1 (log10(2) < 0.31), never fewer than the display width.
    localparam int NAT_DIGITS = (IN_WIDTH * 31) / 100 + 1;
    localparam int BCD_DIGITS = (NAT_DIGITS > DIGITS) ? NAT_DIGITS : DIGITS;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int STEP_W     = $clog2(IN_WIDTH + 1);
    localparam int REF_W      = $clog2(REFRESH_DIV);
    localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [STEP_W-1:0]   step;
    logic [IN_WIDTH-1:0] bin;
    logic [BCD_W-1:0]    bcd;
    logic [BCD_W-1:0]    bcd_adj;
    logic                pend_ovf;
    logic [4*DIGITS-1:0] disp;
    logic [REF_W-1:0]    refresh;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          digit;
    logic [7:0]          glyph;
    logic                lead_zero;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load) next_state = SHIFT;
            SHIFT:   if (step == STEP_W'(IN_WIDTH - 1)) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // Overflow is judged on the captured binary value and only published at commit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step     <= '0;
            bin      <= '0;
            bcd      <= '0;
            pend_ovf <= 1'b0;
            disp     <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin      <= value;
                        bcd      <= '0;
                        step     <= '0;
                        pend_ovf <= (64'(value) >= LIMIT);
                    end
                end
                SHIFT: begin
                    bcd  <= {bcd_adj[BCD_W-2:0], bin[IN_WIDTH-1]};
                    bin  <= {bin[IN_WIDTH-2:0], 1'b0};
                    step <= step + STEP_W'(1);
                end
                COMMIT: begin
                    disp     <= bcd[4*DIGITS-1:0];
                    overflow <= pend_ovf;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            refresh <= '0;
            idx     <= '0;
        end else if (refresh == REF_W'(REFRESH_DIV - 1)) begin
            refresh <= '0;
            if (idx == IDX_W'(DIGITS - 1)) begin
                idx <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end else begin
            refresh <= refresh + REF_W'(1);
        end
    end

    always_comb begin
        anode = ~(DIGITS'(1) << idx);
        digit = disp[4*int'(idx) +: 4];
        case (digit)
            4'd0:    glyph = 8'hC0;
            4'd1:    glyph = 8'hF9;
            4'd2:    glyph = 8'hA4;
            4'd3:    glyph = 8'hB0;
            4'd4:    glyph = 8'h99;
            4'd5:    glyph = 8'h92;
            4'd6:    glyph = 8'h82;
            4'd7:    glyph = 8'hF8;
            4'd8:    glyph = 8'h80;
            4'd9:    glyph = 8'h90;
            default: glyph = 8'hFF;
        endcase
`ifdef SEG_LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
        lead_zero = (idx != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx) && disp[4*i +: 4] != 4'd0) begin
                lead_zero = 1'b0;
            end
        end
`else
        lead_zero = 1'b0;
`endif
        cathode = glyph;
        if (lead_zero) begin
            cathode = 8'hFF;
        end
        if (overflow) begin
            cathode = 8'hBF;
        end
    end

endmodule
